brent_kung16b: RTL and testbench

BRENT_KUNG16B -- requirements
Module: brent_kung16b

---
 rtl/brent_kung16b.sv | 85 ++++++++
 tb/tb_brent_kung16b.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/brent_kung16b.sv
// 16-bit unsigned adder built on an explicit Brent-Kung parallel-prefix carry tree,
// with a combinational sum S and a one-cycle registered copy S_q.
module brent_kung16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [16:0] S,
  output logic [16:0] S_q
);

  logic [15:0] g, p;
  logic [15:0] c;  // c[i] = group generate (i:0)

  // level 1
  logic g1_0, g3_2, g5_4, g7_6, g9_8, g11_10, g13_12, g15_14;
  logic p5_4, p7_6, p9_8, p11_10, p13_12, p15_14;
  // level 2
  logic g3_0, g7_4, g11_8, g15_12;
  logic p7_4, p11_8, p15_12;
  // level 3, 4
  logic g7_0, g15_8, p15_8, g15_0;
  // down-sweep
  logic g11_0, g5_0, g9_0, g13_0;
  logic g2_0, g4_0, g6_0, g8_0, g10_0, g12_0, g14_0;

  assign g = A & B;
  assign p = A ^ B;

  // up-sweep; the group P of (3:2) would only feed the gray (3:0) cell, so it is not built
  assign g1_0   = g[1]  | (p[1]  & g[0]);
  assign g3_2   = g[3]  | (p[3]  & g[2]);
  assign g5_4   = g[5]  | (p[5]  & g[4]);
  assign p5_4   = p[5]  & p[4];
  assign g7_6   = g[7]  | (p[7]  & g[6]);
  assign p7_6   = p[7]  & p[6];
  assign g9_8   = g[9]  | (p[9]  & g[8]);
  assign p9_8   = p[9]  & p[8];
  assign g11_10 = g[11] | (p[11] & g[10]);
  assign p11_10 = p[11] & p[10];
  assign g13_12 = g[13] | (p[13] & g[12]);
  assign p13_12 = p[13] & p[12];
  assign g15_14 = g[15] | (p[15] & g[14]);
  assign p15_14 = p[15] & p[14];

  assign g3_0   = g3_2   | (p[3] & p[2] & g1_0);
  assign g7_4   = g7_6   | (p7_6   & g5_4);
  assign p7_4   = p7_6   & p5_4;
  assign g11_8  = g11_10 | (p11_10 & g9_8);
  assign p11_8  = p11_10 & p9_8;
  assign g15_12 = g15_14 | (p15_14 & g13_12);
  assign p15_12 = p15_14 & p13_12;

  assign g7_0   = g7_4   | (p7_4   & g3_0);
  assign g15_8  = g15_12 | (p15_12 & g11_8);
  assign p15_8  = p15_12 & p11_8;

  assign g15_0  = g15_8  | (p15_8  & g7_0);

  // down-sweep, all gray cells
  assign g11_0  = g11_8  | (p11_8  & g7_0);

  assign g5_0   = g5_4   | (p5_4   & g3_0);
  assign g9_0   = g9_8   | (p9_8   & g7_0);
  assign g13_0  = g13_12 | (p13_12 & g11_0);

  assign g2_0   = g[2]  | (p[2]  & g1_0);
  assign g4_0   = g[4]  | (p[4]  & g3_0);
  assign g6_0   = g[6]  | (p[6]  & g5_0);
  assign g8_0   = g[8]  | (p[8]  & g7_0);
  assign g10_0  = g[10] | (p[10] & g9_0);
  assign g12_0  = g[12] | (p[12] & g11_0);
  assign g14_0  = g[14] | (p[14] & g13_0);

  assign c = {g15_0, g14_0, g13_0, g12_0, g11_0, g10_0, g9_0, g8_0,
              g7_0,  g6_0,  g5_0,  g4_0,  g3_0,  g2_0,  g1_0, g[0]};

  assign S = {c[15], p[15:1] ^ c[14:0], p[0]};

  always_ff @(posedge clk) begin
    if (rst) S_q <= 17'h00000;
    else     S_q <= S;
  end

endmodule

// File: tb/tb_brent_kung16b.sv
// Bench for brent_kung16b: arithmetic reference model checked every cycle,
// plus literal expectations for the directed and register/reset cases.
module tb_brent_kung16b;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [16:0] s, s_q;

  int checks = 0;
  int errors = 0;

  logic [16:0] model_q;
  bit          q_valid = 1'b0;

  always #5 clk = ~clk;

  brent_kung16b dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .S   (s),
    .S_q (s_q)
  );

  // reference register: reset to zero, otherwise holds last cycle's true sum
  always @(posedge clk) begin
    if (rst) begin
      model_q <= 17'h00000;
      q_valid <= 1'b1;
    end else begin
      model_q <= {1'b0, a} + {1'b0, b};
    end
  end

  always @(negedge clk) begin
    logic [16:0] exp_s;
    exp_s = {1'b0, a} + {1'b0, b};
    checks++;
    if (s !== exp_s) begin
      errors++;
      $display("FAIL comb_sum a=%h b=%h got %h want %h", a, b, s, exp_s);
    end
    if (q_valid) begin
      checks++;
      if (s_q !== model_q) begin
        errors++;
        $display("FAIL reg_sum rst=%b got %h want %h", rst, s_q, model_q);
      end
    end
  end

  task automatic expect17(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_check(input logic [15:0] va, input logic [15:0] vb,
                             input logic [16:0] exp, input string name);
    a = va;
    b = vb;
    #1;
    expect17(name, s, exp);
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'h0000;
    b   = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    expect17("reset_sq", s_q, 17'h00000);

    // combinational results while still held in reset
    drive_check(16'h0000, 16'h0000, 17'h00000, "zero");
    drive_check(16'hFFFF, 16'hFFFF, 17'h1FFFE, "max_max");
    drive_check(16'hFFFF, 16'h0001, 17'h10000, "wrap_carry");
    drive_check(16'hAAAA, 16'h5555, 17'h0FFFF, "alt_prop");
    drive_check(16'h8000, 16'h8000, 17'h10000, "msb_carry");
    drive_check(16'h0001, 16'hFFFF, 17'h10000, "wrap_carry_swap");
    expect17("sq_held_in_reset", s_q, 17'h00000);

    // register path
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_check(16'h1234, 16'h4321, 17'h05555, "pre_edge_s");
    @(posedge clk);
    #1;
    expect17("reg_load", s_q, 17'h05555);

    // reset path mid-stream
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect17("reset_mid_sq", s_q, 17'h00000);
    expect17("reset_mid_s", s, 17'h05555);
    rst = 1'b0;
    a = 16'd7;
    b = 16'd9;
    @(posedge clk);
    #1;
    expect17("post_reset_sq", s_q, 17'h00010);

    // carry chains of every length, both operand orders
    for (int i = 0; i <= 16; i++) begin
      logic [16:0] ones;
      ones = (17'h1 << i) - 17'h1;
      a = ones[15:0];
      b = 16'h0001;
      @(posedge clk);
      #1;
      a = 16'h0001;
      b = ones[15:0];
      @(posedge clk);
      #1;
    end

    // single-bit generate positions
    for (int i = 0; i < 16; i++) begin
      a = 16'h0001 << i;
      b = 16'h0001 << i;
      @(posedge clk);
      #1;
    end

    // random operands with occasional mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
